// File: rtl/onehot_regfile.sv
// Sixteen-entry register file with one-hot write select, two registered read ports and write-through bypass.
// Optional macro ONEHOT_CHECK_EN rejects multi-hot writes and raises the sticky wr_err flag.
module onehot_regfile #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [15:0]      wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [3:0]       ra_addr,
  input  logic [3:0]       rb_addr,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data
`ifdef ONEHOT_CHECK_EN
  ,
  output logic             wr_err
`endif
);

  localparam int NREG = 16;

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic             wr_accept;

`ifdef ONEHOT_CHECK_EN
  logic err_q, err_d;

  // True when two or more select bits are set (clearing the lowest set bit leaves something).
  function automatic logic multi_hot(input logic [15:0] sel);
    return (sel & (sel - 16'd1)) != 16'd0;
  endfunction

  assign wr_accept = wr_valid && !multi_hot(wr_sel);
  assign err_d     = err_q | (wr_valid & multi_hot(wr_sel));
  assign wr_err    = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign wr_accept = wr_valid;
`endif

  always_comb begin
    for (int k = 0; k < NREG; k++) begin
      regs_d[k] = (wr_accept && wr_sel[k]) ? wr_data : regs_q[k];
    end
  end

  // Reading the post-write image gives the write-through bypass for free.
  assign ra_d = regs_d[ra_addr];
  assign rb_d = regs_d[rb_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) begin
        regs_q[k] <= '0;
      end
      ra_q <= '0;
      rb_q <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        regs_q[k] <= regs_d[k];
      end
      ra_q <= ra_d;
      rb_q <= rb_d;
    end
  end

  assign ra_data = ra_q;
  assign rb_data = rb_q;

endmodule

// File: tb/tb_onehot_regfile.sv
// Directed plus randomized bench for onehot_regfile against an array-based reference model.
// Build with ONEHOT_CHECK_EN defined to exercise the multi-hot rejection variant.
module tb_onehot_regfile;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic [15:0] wr_sel;
  logic [31:0] wr_data;
  logic [3:0]  ra_addr;
  logic [3:0]  rb_addr;
  logic [31:0] ra_data;
  logic [31:0] rb_data;
`ifdef ONEHOT_CHECK_EN
  logic        wr_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [16];
  bit          m_err;

  onehot_regfile #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .ra_addr  (ra_addr),
    .rb_addr  (rb_addr),
    .ra_data  (ra_data),
    .rb_data  (rb_data)
`ifdef ONEHOT_CHECK_EN
    ,
    .wr_err   (wr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 16; k++) mem[k] = 32'h0;
    m_err = 1'b0;
  endtask

  // Reference behaviour at one rising edge, from the current inputs.
  task automatic model_edge();
    int cnt;
    bit ok;
    if (!rst_n) begin
      model_clear();
      return;
    end
    cnt = $countones(wr_sel);
    ok  = wr_valid && (cnt >= 1);
`ifdef ONEHOT_CHECK_EN
    if (wr_valid && cnt > 1) begin
      ok    = 1'b0;
      m_err = 1'b1;
    end
`endif
    if (ok) begin
      for (int k = 0; k < 16; k++) begin
        if (wr_sel[k]) mem[k] = wr_data;
      end
    end
  endtask

  task automatic check_err();
`ifdef ONEHOT_CHECK_EN
    check("wr_err", {31'b0, wr_err}, {31'b0, m_err});
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("ra_data", ra_data, mem[ra_addr]);
    check("rb_data", rb_data, mem[rb_addr]);
    check_err();
  endtask

  task automatic sweep();
    wr_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      ra_addr = 4'(k);
      rb_addr = 4'(15 - k);
      step();
    end
  endtask

  int          mode;
  logic [15:0] rsel;

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_sel   = 16'h0;
    wr_data  = 32'h0;
    ra_addr  = 4'd5;
    rb_addr  = 4'd15;
    model_clear();
    #2;
    check("rst_ra", ra_data, 32'h0);
    check("rst_rb", rb_data, 32'h0);
    check_err();

    // A write presented on an edge while in reset must be dropped.
    wr_valid = 1'b1;
    wr_sel   = 16'hFFFF;
    wr_data  = 32'hCAFEF00D;
    step();
    #4 rst_n = 1'b1;
    wr_valid = 1'b0;
    step();
    check("rst_first_ra", ra_data, 32'h0);

    // Idle with all selects, then a valid null write.
    wr_valid = 1'b0;
    wr_sel   = 16'hFFFF;
    wr_data  = 32'h55AA55AA;
    step();
    wr_valid = 1'b1;
    wr_sel   = 16'h0;
    step();
    sweep();

    // Single write, then read it and the rest.
    wr_valid = 1'b1;
    wr_sel   = 16'h0008;
    wr_data  = 32'hDEADBEEF;
    ra_addr  = 4'd0;
    rb_addr  = 4'd1;
    step();
    wr_valid = 1'b0;
    ra_addr  = 4'd3;
    step();
    check("wr_rd_r3", ra_data, 32'hDEADBEEF);
    sweep();

    // Bypass with both ports on the same address.
    ra_addr  = 4'd7;
    rb_addr  = 4'd7;
    wr_valid = 1'b1;
    wr_sel   = 16'h0080;
    wr_data  = 32'h12345678;
    step();
    check("byp_ra", ra_data, 32'h12345678);
    check("byp_rb", rb_data, 32'h12345678);

    // Multi-hot select followed by a normal write.
    wr_sel  = 16'h0011;
    wr_data = 32'hA5A5A5A5;
    ra_addr = 4'd0;
    rb_addr = 4'd4;
    step();
    wr_sel  = 16'h0002;
    wr_data = 32'h00000001;
    step();
    wr_valid = 1'b0;
    step();
`ifdef ONEHOT_CHECK_EN
    check("mh_r0", ra_data, 32'h0);
    check("mh_r4", rb_data, 32'h0);
    check("mh_err", {31'b0, wr_err}, 32'h1);
`else
    check("mh_r0", ra_data, 32'hA5A5A5A5);
    check("mh_r4", rb_data, 32'hA5A5A5A5);
`endif
    ra_addr = 4'd1;
    step();
    check("mh_next_wr", ra_data, 32'h00000001);

    // Streaming writes on consecutive cycles, random read addresses meanwhile.
    wr_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wr_sel  = 16'h1 << k;
      wr_data = 32'(k + 1);
      ra_addr = 4'($urandom);
      rb_addr = 4'(k);
      step();
    end
    sweep();
    for (int k = 0; k < 16; k++) begin
      ra_addr = 4'(k);
      step();
      check("stream_rd", ra_data, 32'(k + 1));
    end

    // Reset asserted mid-cycle with a write in flight.
    wr_valid = 1'b1;
    wr_sel   = 16'h0020;
    wr_data  = 32'h0BADC0DE;
    ra_addr  = 4'd5;
    rb_addr  = 4'd15;
    #3 rst_n = 1'b0;
    model_clear();
    #1;
    check("async_ra", ra_data, 32'h0);
    check("async_rb", rb_data, 32'h0);
    check_err();
    step();
    #3 rst_n = 1'b1;
    wr_valid = 1'b0;
    step();
    check("rel_ra", ra_data, 32'h0);
    check("rel_rb", rb_data, 32'h0);
    sweep();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      mode     = int'($urandom_range(0, 3));
      wr_valid = ($urandom_range(0, 3) != 0);
      rsel     = 16'h1 << $urandom_range(0, 15);
      if (mode == 0)      wr_sel = 16'h0;
      else if (mode == 3) wr_sel = 16'($urandom);
      else                wr_sel = rsel;
      wr_data = $urandom;
      ra_addr = 4'($urandom);
      rb_addr = ($urandom_range(0, 3) == 0) ? ra_addr : 4'($urandom);
      step();
      if (ra_addr == rb_addr) check("same_addr", rb_data, ra_data);
    end
    sweep();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
